// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges load-use, divider and exception stalls/flushes.
// Optional PIPE_CTRL_PERF_EN adds saturating stall/flush cycle counters.
module pipe_ctrl #(
   parameter int          DIV_CYCLES = 32,
   parameter logic [31:0] EXC_ENTRY  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        div_start,
   input  logic [4:0]  exc_code,
   input  logic [31:0] cp0_epc,
   output logic [3:0]  stall,
   output logic        flush,
   output logic        flush_im,
   output logic [31:0] cp0_excaddr,
   output logic        div_busy,
   output logic        div_ready
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN,
      DIV,
      FLUSH
   } state_t;

   localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

   state_t      state, state_nx;
   logic [5:0]  cnt, cnt_nx;
   logic        exc, eret;
   logic [3:0]  stall_c;
   logic        flush_c;
   logic [31:0] addr_c;
   logic        busy_c;
   logic        ready_c;
   logic        fim_c;

   assign exc  = (exc_code != 5'h10);
   assign eret = (exc_code == 5'h11);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      stall_c  = 4'b0000;
      flush_c  = 1'b0;
      addr_c   = '0;
      busy_c   = 1'b0;
      unique case (state)
         RUN: begin
            if (exc) begin
               flush_c  = 1'b1;
               addr_c   = eret ? cp0_epc : EXC_ENTRY;
               state_nx = FLUSH;
            end else if (div_start) begin
               stall_c  = 4'b0111;
               busy_c   = 1'b1;
               cnt_nx   = CNT_LOAD;
               state_nx = DIV;
            end else if (stallreq_id) begin
               stall_c  = 4'b0011;
            end
         end
         DIV: begin
            // Counter is decoded for busy/ready regardless of abort.
            busy_c = (cnt != 6'd0);
            if (exc) begin
               flush_c  = 1'b1;
               addr_c   = eret ? cp0_epc : EXC_ENTRY;
               cnt_nx   = '0;
               state_nx = FLUSH;
            end else if (cnt != 6'd0) begin
               stall_c  = 4'b0111;
               cnt_nx   = cnt - 6'd1;
            end else begin
               state_nx = RUN;
            end
         end
         FLUSH: begin
            state_nx = RUN;
         end
         default: begin
            state_nx = RUN;
         end
      endcase
   end

   assign ready_c = (state == DIV) && (cnt == 6'd0);
   assign fim_c   = (state == FLUSH);

   // Reset forces every output low even though most are combinational.
   assign stall       = rst ? 4'b0000 : stall_c;
   assign flush       = rst ? 1'b0 : flush_c;
   assign cp0_excaddr = rst ? 32'h0 : addr_c;
   assign div_busy    = rst ? 1'b0 : busy_c;
   assign div_ready   = rst ? 1'b0 : ready_c;
   assign flush_im    = rst ? 1'b0 : fim_c;

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if ((stall_c != 4'b0000) && (perf_stall_cnt != 32'hFFFF_FFFF))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (flush_c && (perf_flush_cnt != 32'hFFFF_FFFF))
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule
